// File: rtl/tt_io_trace_buffer.sv
// tt_io_trace_buffer
//   Capture/replay trace buffer for on-chip self-test. After a masked
//   trigger, WIDTH-bit samples of din are written into a DEPTH-entry RAM
//   every div+1 cycles. A replay command later drives the stored samples
//   back out on dout, once or looped, holding each entry for div+1 cycles.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   ena                 block enable; low aborts to IDLE, RAM and count kept
//   start, mode         command pulse in IDLE; mode 0 = capture, 1 = replay
//   loop_en             replay wraps to entry 0 instead of finishing
//   stop                ends ARM / CAPTURE / REPLAY
//   div                 sample / replay period minus one
//   trig_val, trig_mask trigger compare value and participating bits
//   din                 sampled input bus
//   dout, dout_oe       replay data and its output enable (all 1s in REPLAY)
//   busy                high in ARM, CAPTURE, REPLAY
//   done                1-cycle pulse on the first IDLE cycle after DONE
//   count               number of valid captured entries
module tt_io_trace_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int DIVW  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic                         start,
  input  logic                         mode,
  input  logic                         loop_en,
  input  logic                         stop,
  input  logic [DIVW-1:0]              div,
  input  logic [WIDTH-1:0]             trig_val,
  input  logic [WIDTH-1:0]             trig_mask,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [WIDTH-1:0]             dout_oe,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_CAPTURE, S_REPLAY, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DIVW-1:0]   tick_q, tick_d;
  logic [DIVW-1:0]   div_q, div_d;      // period latched at each tick reload
  logic [AW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  dout_q;
  logic [WIDTH-1:0]  oe_q;
  logic              busy_q;
  logic              done_q;

  logic              we;
  logic [AW-1:0]     waddr;
  logic              trig_hit;
  logic              tick_end;
  logic              last_entry;

  logic [WIDTH-1:0]  mem [DEPTH];

  assign trig_hit   = ((din ^ trig_val) & trig_mask) == '0;
  assign tick_end   = (tick_q == div_q);
  assign last_entry = ((CW'(idx_q) + CW'(1)) == count_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = tick_q;
    div_d   = div_q;
    idx_d   = idx_q;
    we      = 1'b0;
    waddr   = count_q[AW-1:0];

    if (!ena) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (!mode) begin
              state_d = S_ARM;
              count_d = '0;
            end else if (count_q != '0) begin
              state_d = S_REPLAY;
              idx_d   = '0;
              tick_d  = '0;
              div_d   = div;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_ARM: begin
          // stop outranks a coincident trigger: nothing is written
          if (stop) begin
            state_d = S_DONE;
          end else if (trig_hit) begin
            we      = 1'b1;
            waddr   = '0;
            count_d = CW'(1);
            tick_d  = '0;
            div_d   = div;
            state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (tick_end) begin
            we      = 1'b1;
            count_d = count_q + CW'(1);
            tick_d  = '0;
            div_d   = div;
            if (count_q == CW'(DEPTH-1)) state_d = S_DONE;
          end else begin
            tick_d = tick_q + DIVW'(1);
          end
          // a write landing on the same cycle as stop still completes
          if (stop) state_d = S_DONE;
        end
        S_REPLAY: begin
          if (stop) begin
            state_d = S_DONE;
          end else if (tick_end) begin
            tick_d = '0;
            div_d  = div;
            if (last_entry) begin
              if (loop_en) idx_d = '0;
              else         state_d = S_DONE;
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end else begin
            tick_d = tick_q + DIVW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // No reset on the array; the write enable derives from state_q, which
  // reset forces to IDLE immediately, so no write can land after rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      tick_q  <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      oe_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d == S_ARM) || (state_d == S_CAPTURE) || (state_d == S_REPLAY);
      oe_q    <= (state_d == S_REPLAY) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
      // an ena-low abort out of DONE suppresses the pulse
      done_q  <= (state_q == S_DONE) && ena;
      // read with the next index so the first REPLAY cycle already shows entry 0;
      // outside REPLAY dout keeps its last value
      if (state_d == S_REPLAY) dout_q <= mem[idx_d];
    end
  end

  assign dout    = dout_q;
  assign dout_oe = oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign count   = count_q;

endmodule

// File: tb/tb_tt_io_trace_buffer.sv
module tb_tt_io_trace_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       loop_en = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] div = 8'd0;
  logic [7:0] trig_val = 8'd0;
  logic [7:0] trig_mask = 8'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;
  logic [7:0] dout_oe;
  logic       busy;
  logic       done;
  logic [4:0] count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         tag;
    logic [4:0] cnt;
    logic       busy;
    logic       done;
    logic [7:0] oe;
    bit         chk_dout;
    logic [7:0] dout;
  } status_t;

  status_t    st_q[$];
  logic [7:0] dout_exp_q[$];

  tt_io_trace_buffer #(.WIDTH(8), .DEPTH(16), .DIVW(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .mode(mode),
    .loop_en(loop_en), .stop(stop), .div(div), .trig_val(trig_val),
    .trig_mask(trig_mask), .din(din), .dout(dout), .dout_oe(dout_oe),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input int tag, input logic [4:0] c, input logic b,
                           input logic d, input logic [7:0] oe,
                           input bit cd, input logic [7:0] dv);
    status_t s;
    s.tag = tag; s.cnt = c; s.busy = b; s.done = d; s.oe = oe;
    s.chk_dout = cd; s.dout = dv;
    st_q.push_back(s);
  endtask

  // Monitor: replay data is popped whenever the DUT drives dout_oe;
  // status expectations are popped on the negedge following their issue.
  initial begin
    status_t s;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (dout_oe == 8'hFF) begin
        checks++;
        if (dout_exp_q.size() == 0) begin
          failures++;
          $display("FAIL replay_extra got dout=%02h with no expected entry", dout);
        end else begin
          e = dout_exp_q.pop_front();
          if (dout !== e) begin
            failures++;
            $display("FAIL replay_data got=%02h exp=%02h", dout, e);
          end else $display("replay dout=%02h ok", dout);
        end
      end else if (dout_oe !== 8'h00) begin
        checks++; failures++;
        $display("FAIL replay_oe got=%02h exp=00 or FF", dout_oe);
      end
      if (st_q.size() != 0) begin
        s = st_q.pop_front();
        checks += 4;
        if (count !== s.cnt) begin
          failures++; $display("FAIL st%0d.count got=%0d exp=%0d", s.tag, count, s.cnt);
        end
        if (busy !== s.busy) begin
          failures++; $display("FAIL st%0d.busy got=%0b exp=%0b", s.tag, busy, s.busy);
        end
        if (done !== s.done) begin
          failures++; $display("FAIL st%0d.done got=%0b exp=%0b", s.tag, done, s.done);
        end
        if (dout_oe !== s.oe) begin
          failures++; $display("FAIL st%0d.dout_oe got=%02h exp=%02h", s.tag, dout_oe, s.oe);
        end
        if (s.chk_dout) begin
          checks++;
          if (dout !== s.dout) begin
            failures++; $display("FAIL st%0d.dout got=%02h exp=%02h", s.tag, dout, s.dout);
          end
        end
        $display("status %0d count=%0d busy=%0b done=%0b oe=%02h dout=%02h",
                 s.tag, count, busy, done, dout_oe, dout);
      end
    end
  end

  initial begin
    int j;
    // 1: reset and idle
    step();
    expect_st(1, 5'd0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    step();
    rst = 1'b0;
    step();
    expect_st(2, 5'd0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    step();

    // 2: immediate trigger, div=0, fill all 16 entries
    trig_mask = 8'h00; div = 8'd0; mode = 1'b0; start = 1'b1; din = 8'h10;
    step();
    start = 1'b0;
    expect_st(10, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      din = 8'h10 + 8'(i);
      step();
      expect_st(11 + i, 5'(i + 1), (i < 15), 1'b0, 8'h00, 1'b0, 8'h00);
    end
    step();
    expect_st(30, 5'd16, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    step();
    expect_st(31, 5'd16, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // replay the full buffer once, one cycle per entry
    for (int i = 0; i < 16; i++) dout_exp_q.push_back(8'h10 + 8'(i));
    mode = 1'b1; loop_en = 1'b0; div = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (16) step();
    expect_st(32, 5'd16, 1'b0, 1'b0, 8'h00, 1'b1, 8'h1F);
    step();
    expect_st(33, 5'd16, 1'b0, 1'b1, 8'h00, 1'b1, 8'h1F);
    step();

    // 3: masked trigger on upper nibble A, div=2, din sweeping
    trig_mask = 8'hF0; trig_val = 8'hA0; div = 8'd2; mode = 1'b0;
    din = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    expect_st(40, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    j = 0;
    do begin
      din = 8'(j);
      step();
      j++;
    end while (count != 5'd4 && j < 300);
    stop = 1'b1;
    step();
    stop = 1'b0;
    expect_st(41, 5'd4, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    step();
    expect_st(42, 5'd4, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    step();

    // 4: single replay, div=1
    dout_exp_q.push_back(8'hA0); dout_exp_q.push_back(8'hA0);
    dout_exp_q.push_back(8'hA3); dout_exp_q.push_back(8'hA3);
    dout_exp_q.push_back(8'hA6); dout_exp_q.push_back(8'hA6);
    dout_exp_q.push_back(8'hA9); dout_exp_q.push_back(8'hA9);
    mode = 1'b1; div = 8'd1; loop_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    expect_st(50, 5'd4, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA9);
    step();
    expect_st(51, 5'd4, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA9);
    step();

    // 5: looped replay wraps, then stop mid-entry
    dout_exp_q.push_back(8'hA0); dout_exp_q.push_back(8'hA0);
    dout_exp_q.push_back(8'hA3); dout_exp_q.push_back(8'hA3);
    dout_exp_q.push_back(8'hA6); dout_exp_q.push_back(8'hA6);
    dout_exp_q.push_back(8'hA9); dout_exp_q.push_back(8'hA9);
    dout_exp_q.push_back(8'hA0); dout_exp_q.push_back(8'hA0);
    dout_exp_q.push_back(8'hA3);
    loop_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    expect_st(60, 5'd4, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA3);
    step();
    expect_st(61, 5'd4, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA3);
    step();

    // 6: ena abort mid-capture at count=5
    trig_mask = 8'h00; div = 8'd2; mode = 1'b0; din = 8'h55; start = 1'b1;
    step();
    start = 1'b0;
    j = 0;
    while (count != 5'd5 && j < 200) begin
      step();
      j++;
    end
    ena = 1'b0;
    step();
    expect_st(70, 5'd5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    step();
    expect_st(71, 5'd5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    ena = 1'b1;
    step();

    // async reset during replay
    dout_exp_q.push_back(8'h55); dout_exp_q.push_back(8'h55);
    mode = 1'b1; div = 8'd0; loop_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    expect_st(80, 5'd0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    step();
    expect_st(81, 5'd0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    rst = 1'b0;
    step();
    step();

    checks++;
    if (dout_exp_q.size() != 0 || st_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained got replay=%0d status=%0d exp=0 0",
               dout_exp_q.size(), st_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
